// File: rtl/sdp_ram_pipe.sv
// Simple dual-port single-clock RAM with byte-lane writes, a 1..3 stage read
// pipeline with valid/collision flags. Optional macro: SDP_RAM_BYPASS_EN (write-first collisions).
module sdp_ram_pipe #(
    parameter int    DSIZE     = 32,
    parameter int    ASIZE     = 10,
    parameter int    NBE       = 4,
    parameter int    RD_LAT    = 2,
    parameter string INIT_FILE = ""
) (
    input  logic             clka,
    input  logic             rst,
    input  logic [ASIZE-1:0] addra,
    input  logic [DSIZE-1:0] dina,
    input  logic             wea,
    input  logic [NBE-1:0]   bea,
    input  logic [ASIZE-1:0] addrb,
    input  logic             enb,
    output logic [DSIZE-1:0] doutb,
    output logic             validb,
    output logic             collb
);

    localparam int LW    = DSIZE / NBE;
    localparam int DEPTH = 1 << ASIZE;

    generate
        if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
            $error("sdp_ram_pipe: RD_LAT must be 1..3");
        end
        if (DSIZE % NBE != 0) begin : g_bad_lanes
            $error("sdp_ram_pipe: DSIZE must be a multiple of NBE");
        end
    endgenerate

    logic [DSIZE-1:0] mem [DEPTH];

    // Power-up contents: all zeros.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    // NOTE: the array has no reset; clearing it would stop block-RAM inference.
    always_ff @(posedge clka) begin
        for (int k = 0; k < NBE; k++) begin
            if (wea && bea[k]) mem[addra][k*LW +: LW] <= dina[k*LW +: LW];
        end
    end

    logic             coll;
    logic [DSIZE-1:0] rd_word;

    assign coll = wea && enb && (addra == addrb);

`ifdef SDP_RAM_BYPASS_EN
    // NOTE: rd_word gets its default first so the lane overrides cannot infer a latch.
    always_comb begin
        rd_word = mem[addrb];
        if (coll) begin
            for (int k = 0; k < NBE; k++) begin
                if (bea[k]) rd_word[k*LW +: LW] = dina[k*LW +: LW];
            end
        end
    end
`else
    assign rd_word = mem[addrb];
`endif

    logic [DSIZE-1:0]  dat [RD_LAT];
    logic [RD_LAT-1:0] vld;
    logic [RD_LAT-1:0] col;

    // Valid/collision bits shift every cycle; data stages load only behind a valid.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            vld <= '0;
            col <= '0;
            for (int i = 0; i < RD_LAT; i++) dat[i] <= '0;
        end else begin
            vld[0] <= enb;
            col[0] <= coll;
            if (enb) dat[0] <= rd_word;
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
                col[i] <= col[i-1];
                if (vld[i-1]) dat[i] <= dat[i-1];
            end
        end
    end

    assign doutb  = dat[RD_LAT-1];
    assign validb = vld[RD_LAT-1];
    assign collb  = col[RD_LAT-1];

endmodule

// File: tb/tb_sdp_ram_pipe.sv
// Bench for sdp_ram_pipe: three instances (RD_LAT 1..3) share stimulus and are
// compared every cycle against a per-edge history model, plus literal checks.
module tb_sdp_ram_pipe;

    logic        clka;
    logic        rst;
    logic [9:0]  addra;
    logic [31:0] dina;
    logic        wea;
    logic [3:0]  bea;
    logic [9:0]  addrb;
    logic        enb;

    logic [31:0] doutb_a  [1:3];
    logic        validb_a [1:3];
    logic        collb_a  [1:3];

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar g = 1; g <= 3; g++) begin : g_dut
        sdp_ram_pipe #(
            .DSIZE(32), .ASIZE(10), .NBE(4), .RD_LAT(g), .INIT_FILE("")
        ) u_dut (
            .clka   (clka),
            .rst    (rst),
            .addra  (addra),
            .dina   (dina),
            .wea    (wea),
            .bea    (bea),
            .addrb  (addrb),
            .enb    (enb),
            .doutb  (doutb_a[g]),
            .validb (validb_a[g]),
            .collb  (collb_a[g])
        );
    end

    initial clka = 1'b0;
    always #5 clka = ~clka;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

`ifdef SDP_RAM_BYPASS_EN
    localparam logic [31:0] EXP_COLL = 32'h0000FFFF;
`else
    localparam logic [31:0] EXP_COLL = 32'h00000000;
`endif

    // Model: what each clock edge requested, and the word a read at that edge returns.
    bit [31:0] model_mem [0:1023];
    bit        hist_v [0:4095];
    bit        hist_c [0:4095];
    bit [31:0] hist_d [0:4095];
    bit [31:0] exp_d  [1:3];
    int        edge_cnt = 0;

    always @(posedge clka) begin
        bit [31:0] w;
        bit        c;
        edge_cnt++;
        w = model_mem[addrb];
        c = wea && enb && (addra == addrb);
`ifdef SDP_RAM_BYPASS_EN
        if (c) begin
            for (int k = 0; k < 4; k++) if (bea[k]) w[k*8 +: 8] = dina[k*8 +: 8];
        end
`endif
        hist_v[edge_cnt] = !rst && enb;
        hist_c[edge_cnt] = !rst && c;
        hist_d[edge_cnt] = w;
        if (wea) begin
            for (int k = 0; k < 4; k++) if (bea[k]) model_mem[addra][k*8 +: 8] = dina[k*8 +: 8];
        end
    end

    // Reset discards every read in flight and clears the held output word.
    always @(posedge rst) begin
        for (int i = 0; i < 4096; i++) begin
            hist_v[i] = 1'b0;
            hist_c[i] = 1'b0;
        end
        for (int l = 1; l <= 3; l++) exp_d[l] = '0;
    end

    always @(negedge clka) begin
        for (int l = 1; l <= 3; l++) begin
            int idx;
            bit ev;
            bit ec;
            idx = edge_cnt - l + 1;
            ev  = (idx >= 1) ? hist_v[idx] : 1'b0;
            ec  = ev && hist_c[idx];
            if (ev) exp_d[l] = hist_d[idx];
            check($sformatf("cmp_validb_L%0d", l), {31'b0, validb_a[l]}, {31'b0, ev});
            check($sformatf("cmp_collb_L%0d", l), {31'b0, collb_a[l]}, {31'b0, ec});
            check($sformatf("cmp_doutb_L%0d", l), doutb_a[l], exp_d[l]);
        end
    end

    task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
        addra = a;
        dina  = d;
        bea   = b;
        wea   = 1'b1;
        @(negedge clka);
        wea   = 1'b0;
        bea   = 4'b0;
    endtask

    task automatic rd(input logic [9:0] a);
        addrb = a;
        enb   = 1'b1;
        @(negedge clka);
        enb   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clka);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt [1:3];

        rst = 1'b1; wea = 1'b0; enb = 1'b0; bea = 4'b0;
        addra = '0; addrb = '0; dina = '0;
        #1;
        for (int l = 1; l <= 3; l++) begin
            check($sformatf("reset_validb_L%0d", l), {31'b0, validb_a[l]}, 32'd0);
            check($sformatf("reset_doutb_L%0d", l), doutb_a[l], 32'd0);
        end
        idle(3);
        rst = 1'b0;

        // Latency: result appears exactly RD_LAT cycles after the request edge.
        wr(10'h005, 32'hDEADBEEF, 4'hF);
        idle(2);
        rd(10'h005);
        for (int k = 1; k <= 4; k++) begin
            for (int l = 1; l <= 3; l++) begin
                check($sformatf("lat_validb_L%0d_k%0d", l, k), {31'b0, validb_a[l]}, {31'b0, k == l});
                if (k == l) check($sformatf("lat_doutb_L%0d", l), doutb_a[l], 32'hDEADBEEF);
            end
            @(negedge clka);
        end

        // Byte lanes.
        wr(10'h010, 32'h11223344, 4'hF);
        wr(10'h010, 32'hAABBCCDD, 4'b0101);
        rd(10'h010);
        idle(4);
        for (int l = 1; l <= 3; l++)
            check($sformatf("lanes_doutb_L%0d", l), doutb_a[l], 32'h11BB33DD);

        // Collision on the same edge.
        wr(10'h020, 32'h00000000, 4'hF);
        addra = 10'h020; dina = 32'hFFFFFFFF; bea = 4'b0011; wea = 1'b1;
        addrb = 10'h020; enb = 1'b1;
        @(negedge clka);
        wea = 1'b0; enb = 1'b0; bea = 4'b0;
        for (int k = 1; k <= 4; k++) begin
            for (int l = 1; l <= 3; l++)
                check($sformatf("coll_collb_L%0d_k%0d", l, k), {31'b0, collb_a[l]}, {31'b0, k == l});
            @(negedge clka);
        end
        for (int l = 1; l <= 3; l++)
            check($sformatf("coll_doutb_L%0d", l), doutb_a[l], EXP_COLL);

        // Streaming: 16 back-to-back reads.
        for (int a = 0; a < 16; a++) wr(10'(a), 32'(a * 3), 4'hF);
        for (int l = 1; l <= 3; l++) cnt[l] = 0;
        enb = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i < 16) addrb = 10'(i);
            else enb = 1'b0;
            @(negedge clka);
            for (int l = 1; l <= 3; l++) cnt[l] += int'(validb_a[l]);
        end
        for (int l = 1; l <= 3; l++) begin
            check($sformatf("stream_count_L%0d", l), 32'(cnt[l]), 32'd16);
            check($sformatf("stream_last_L%0d", l), doutb_a[l], 32'd45);
        end

        // Hold at the top address.
        wr(10'h3FF, 32'hCAFEF00D, 4'hF);
        rd(10'h3FF);
        idle(4);
        for (int k = 0; k < 3; k++) begin
            for (int l = 1; l <= 3; l++) begin
                check($sformatf("hold_validb_L%0d", l), {31'b0, validb_a[l]}, 32'd0);
                check($sformatf("hold_doutb_L%0d", l), doutb_a[l], 32'hCAFEF00D);
            end
            @(negedge clka);
        end

        // Reset mid-stream with two reads in flight.
        enb = 1'b1; addrb = 10'h005;
        @(negedge clka);
        addrb = 10'h010;
        @(negedge clka);
        enb = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int l = 1; l <= 3; l++) begin
            check($sformatf("rst_validb_L%0d", l), {31'b0, validb_a[l]}, 32'd0);
            check($sformatf("rst_collb_L%0d", l), {31'b0, collb_a[l]}, 32'd0);
            check($sformatf("rst_doutb_L%0d", l), doutb_a[l], 32'd0);
        end
        idle(2);
        rst = 1'b0;
        cnt[3] = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clka);
            cnt[3] += int'(validb_a[3]);
        end
        check("rst_no_delivery_L3", 32'(cnt[3]), 32'd0);
        rd(10'h3FF);
        idle(4);
        for (int l = 1; l <= 3; l++)
            check($sformatf("post_rst_doutb_L%0d", l), doutb_a[l], 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
